rs_ctrl_16b: RTL
================

RS_CTRL_16B -- requirements
Module: rs_ctrl_16b

Interface
REQ-001 SHALL have parameter DEPTH, default 16, stack entries. Only 16 is supported, with the index taken from rp[3:0].
REQ-002 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset is synchronous and active-high.
REQ-004 SHALL have port call, input, 1, push request; carries the return address on pc_in.
REQ-005 SHALL have port ret, input, 1, pop request.
REQ-006 SHALL have port pc_in, input, 16, return address to push.
REQ-007 SHALL have port rp, input, 16, current stack pointer from the ss_rp_16b pointer stage.
REQ-008 SHALL have port rp_src, output, 2, select driven to ss_rp_16b: 00 hold (+0), 01 increment (+1), 10 decrement (-1); 11 never driven.
REQ-009 SHALL have port pc_out, output, 16, popped return address (registered).
REQ-010 SHALL have port pc_valid, output, 1, one-cycle strobe qualifying pc_out.
REQ-011 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-012 SHALL have port overflow, output, 1, sticky flag: push attempted while full.
REQ-013 SHALL have port underflow, output, 1, sticky flag: pop attempted while empty.

Function
REQ-014 SHALL hold internal storage mem[0..15] x 16 bits, indexed by rp[3:0], plus a 5-bit occupancy count (0..16).
REQ-015 SHALL implement FSM states IDLE, PUSH, POP1 and POP2; busy = (state != IDLE).
REQ-016 SHALL sample call/ret only in IDLE; requests raised in any other state SHALL be ignored, not queued.
REQ-017 IDLE with call=1 and count<16: SHALL latch pc_in, go to PUSH.
REQ-018 PUSH: SHALL write mem[rp[3:0]] <= latched pc_in, drive rp_src=01 for exactly this cycle, count+1, go to IDLE.
REQ-019 IDLE with ret=1 (call=0) and count>0: SHALL go to POP1.
REQ-020 POP1: SHALL drive rp_src=10 for exactly this cycle, count-1, go to POP2.
REQ-021 POP2: SHALL register pc_out <= mem[rp[3:0]] (pointer already decremented), set pc_valid=1 for the following cycle only, go to IDLE.
REQ-022 SHALL drive rp_src=00 in IDLE and POP2.
REQ-023 call latency: accept at cycle T, write and increment at T+1, IDLE at T+2.
REQ-024 ret latency: accept at T, decrement at T+1, read at T+2, pc_valid and pc_out valid at T+3, IDLE at T+3.
REQ-025 Simultaneous call=1 and ret=1 in IDLE: call SHALL take priority and ret SHALL be dropped silently.
REQ-026 call in IDLE with count==16: SHALL set overflow; no write, no rp_src change, stay IDLE.
REQ-027 ret in IDLE with count==0: SHALL set underflow; no rp_src change, pc_valid stays 0, stay IDLE.
REQ-028 overflow and underflow SHALL clear only on reset.
REQ-029 pc_out SHALL hold its last value between pops.
REQ-030 rp_src SHALL be a combinational decode of state and reset only; no path from call/ret/pc_in to rp_src.

Reset
REQ-031 While reset=1, rp_src SHALL be forced to 00.
REQ-032 On a clock edge with reset=1: state IDLE, count 0, pc_out 0x0000, pc_valid 0, overflow 0, underflow 0; busy and rp_src SHALL read 0 and 00 the following cycle.
REQ-033 Reset asserted in PUSH, POP1 or POP2 SHALL abort the operation: no pc_valid pulse, count 0; mem contents are not cleared and are not guaranteed.

Verification
REQ-034 reset; call with pc_in=0x1234 -> rp_src=01 at T+1, count 1, busy high T+1 only; ret -> rp_src=10 at T+1, pc_out=0x1234 with pc_valid=1 at T+3 only.
REQ-035 push 0x0A00, 0x0B00, 0x0C00; pop three times -> pc_out sequence 0x0C00, 0x0B00, 0x0A00; fourth ret -> underflow=1, no pc_valid, rp_src stays 00.
REQ-036 16 pushes -> 17th call sets overflow=1, rp_src stays 00, count stays 16; a following ret returns the 16th pushed value.
REQ-037 call=1 and ret=1 together in IDLE with pc_in=0x5555 -> push occurs, no pop, count+1; call held high during PUSH -> only one push.
REQ-038 reset asserted during POP1 -> next cycle rp_src=00, busy=0, no pc_valid, overflow and underflow 0; subsequent ret -> underflow=1.

Source files
------------

// File: rtl/rs_ctrl_16b.sv
// Return-address stack controller: 16-entry storage addressed by an external pointer
// stage (ss_rp_16b), which this block steers through rp_src.
//
// state | meaning
// IDLE  | waiting; samples call/ret, call wins when both are high
// PUSH  | write latched return address at rp, pointer +1
// POP1  | pointer -1
// POP2  | read entry at (decremented) rp into pc_out, strobe pc_valid
module rs_ctrl_16b #(
   parameter int DEPTH = 16
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        call,
   input  logic        ret,
   input  logic [15:0] pc_in,
   input  logic [15:0] rp,
   output logic [1:0]  rp_src,
   output logic [15:0] pc_out,
   output logic        pc_valid,
   output logic        busy,
   output logic        overflow,
   output logic        underflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PUSH = 2'd1,
      POP1 = 2'd2,
      POP2 = 2'd3
   } state_t;

   state_t      r_state;
   logic [4:0]  r_count;
   logic [15:0] r_pc_lat;
   logic [15:0] r_mem [0:DEPTH-1];
   logic [3:0]  w_idx;
   logic        w_rp_unused;

   assign w_idx       = rp[3:0];
   assign w_rp_unused = ^rp[15:4];

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state   <= IDLE;
         r_count   <= 5'd0;
         r_pc_lat  <= 16'h0000;
         pc_out    <= 16'h0000;
         pc_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         pc_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (call) begin
                  if (r_count == 5'(DEPTH)) begin
                     overflow <= 1'b1;
                  end else begin
                     r_pc_lat <= pc_in;
                     r_state  <= PUSH;
                  end
               end else if (ret) begin
                  if (r_count == 5'd0) begin
                     underflow <= 1'b1;
                  end else begin
                     r_state <= POP1;
                  end
               end
            end
            PUSH: begin
               r_count <= r_count + 5'd1;
               r_state <= IDLE;
            end
            POP1: begin
               r_count <= r_count - 5'd1;
               r_state <= POP2;
            end
            POP2: begin
               pc_out   <= r_mem[w_idx];
               pc_valid <= 1'b1;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Storage is deliberately left out of reset; a reset mid-PUSH suppresses the write.
   always_ff @(posedge CLK) begin
      if (!reset && r_state == PUSH) begin
         r_mem[w_idx] <= r_pc_lat;
      end
   end

   always_comb begin
      rp_src = 2'b00;
      if (!reset) begin
         case (r_state)
            PUSH:    rp_src = 2'b01;
            POP1:    rp_src = 2'b10;
            default: rp_src = 2'b00;
         endcase
      end
   end

   assign busy = (r_state != IDLE);

endmodule
